// File: rtl/lavigne_pkg.sv
// Shared types and defaults for the lavigne drive scheduler.
// Holds the FSM state type, default parameters and an index-width helper.
package lavigne_pkg;

  localparam int NREQ_DEF = 4;
  localparam int LENW_DEF = 4;
  localparam int GAP_DEF  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } lavigne_sched_state_e;

  // Width of an index into n entries, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lavigne_rr_arb.sv
// Combinational round-robin arbiter: search starts one past ptr_i.
// Ports: req_i (levels), ptr_i (last winner) -> oh_o (one-hot), idx_o.
module lavigne_rr_arb
  import lavigne_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] oh_o,
  output logic [IW-1:0]   idx_o
);

  int   j;
  logic found;

  always_comb begin
    oh_o  = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_i[j]) begin
        found   = 1'b1;
        oh_o[j] = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/lavigne_sched.sv
// Shares the a1/b2 drive lines between NREQ requesters, round-robin.
// Ports: clk, reset, req/req_tgt/req_len in; gnt, a1, b2, busy, done out.
module lavigne_sched
  import lavigne_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int LENW = LENW_DEF,
  parameter int GAP  = GAP_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_tgt,
  input  logic [NREQ*LENW-1:0] req_len,
  output logic [NREQ-1:0]      gnt,
  output logic                 a1,
  output logic                 b2,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = idx_w(NREQ);
  localparam int GW = $clog2(GAP + 1) + 1;

  localparam logic [IW-1:0] PTR_RST  = IW'(NREQ - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  // A zero-length grant spends its acceptance cycle in GAP too.
  localparam logic [GW-1:0] GAP_ZERO = GW'(GAP);

  lavigne_sched_state_e state_q, state_d;

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic            tgt_q, tgt_d;
  logic            zdone_q, zdone_d;
  logic [NREQ-1:0] gnt_q, gnt_d;

  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic [LENW-1:0] sel_len;
  logic            sel_tgt;

  lavigne_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .oh_o  (win_oh),
    .idx_o (win_idx)
  );

  always_comb begin
    sel_len = '0;
    sel_tgt = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        sel_len = req_len[i*LENW +: LENW];
        sel_tgt = req_tgt[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    tgt_d   = tgt_q;
    zdone_d = 1'b0;
    gnt_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d = win_oh;
          ptr_d = win_idx;
          tgt_d = sel_tgt;
          if (sel_len == '0) begin
            state_d = S_GAP;
            gcnt_d  = GAP_ZERO;
            cnt_d   = '0;
            zdone_d = 1'b1;
          end else begin
            state_d = S_DRIVE;
            cnt_d   = sel_len - LENW'(1);
          end
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          gcnt_d  = GAP_LAST;
        end else begin
          cnt_d = cnt_q - LENW'(1);
        end
      end
      S_GAP: begin
        if (gcnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      tgt_q   <= 1'b0;
      zdone_q <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      tgt_q   <= tgt_d;
      zdone_q <= zdone_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign a1   = (state_q == S_DRIVE) && !tgt_q;
  assign b2   = (state_q == S_DRIVE) &&  tgt_q;
  assign busy = (state_q != S_IDLE);
  assign done = ((state_q == S_DRIVE) && (cnt_q == '0)) || zdone_q;

endmodule

// File: tb/tb_lavigne_sched.sv
// Bench for lavigne_sched: directed scenarios plus randomized traffic.
// Expected outputs come from a transaction-level timing model.
module tb_lavigne_sched;

  localparam int NREQ = 4;
  localparam int LENW = 4;
  localparam int GAP  = 1;
  localparam int VW   = NREQ + 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ-1:0]      req_tgt = '0;
  logic [NREQ*LENW-1:0] req_len = '0;
  logic [NREQ-1:0]      gnt;
  logic                 a1, b2, busy, done;

  lavigne_sched #(
    .NREQ (NREQ),
    .LENW (LENW),
    .GAP  (GAP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_tgt (req_tgt),
    .req_len (req_len),
    .gnt     (gnt),
    .a1      (a1),
    .b2      (b2),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: one remembered transaction (accept edge k, length L).
  int          m_ptr  = NREQ - 1;
  int          m_k    = 0;
  int          m_L    = 0;
  int          m_w    = 0;
  int          m_free = 0;
  bit          m_act  = 0;
  bit          m_tgt  = 0;
  logic [VW-1:0]   e_vec;
  logic [NREQ-1:0] e_gnt;

  function automatic logic [VW-1:0] obs();
    return {gnt, a1, b2, busy, done};
  endfunction

  // Cycle c lies between edge c-1 and edge c.
  task automatic tick();
    int  n, w, c;
    bit  drv, dn;
    @(posedge clk);
    n = cyc;
    if (reset) begin
      m_act  = 0;
      m_free = n + 1;
      m_ptr  = NREQ - 1;
    end else if (n >= m_free && req != '0) begin
      w = -1;
      for (int o = 1; o <= NREQ; o++) begin
        int j;
        j = (m_ptr + o) % NREQ;
        if (w < 0 && req[j]) w = j;
      end
      m_act  = 1;
      m_k    = n;
      m_w    = w;
      m_ptr  = w;
      m_tgt  = req_tgt[w];
      m_L    = int'(req_len[w*LENW +: LENW]);
      m_free = (m_L > 0) ? n + m_L + GAP + 1 : n + GAP + 2;
    end
    cyc = n + 1;
    c = cyc;
    e_gnt = '0;
    drv = 0;
    dn = 0;
    if (m_act) begin
      if (c == m_k + 1) e_gnt[m_w] = 1'b1;
      drv = (m_L > 0) && (c >= m_k + 1) && (c <= m_k + m_L);
      dn  = (m_L > 0) ? (c == m_k + m_L) : (c == m_k + 1);
    end
    e_vec = {e_gnt, drv && !m_tgt, drv && m_tgt, c < m_free, dn};
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && cyc < m_free; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0;
    tick();
    tick();
    n_cmp++;
    if (obs() !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b want=%b", obs(), {VW{1'b0}});
    end
    n_cmp++;
    if (obs() !== e_vec) begin
      n_bad++;
      $display("FAIL reset_model got=%b want=%b", obs(), e_vec);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int t0, r;
    req[0] = 1'b1;
    req_tgt[0] = 1'b0;
    req_len[0 +: LENW] = LENW'(3);
    t0 = cyc;
    for (int s = 0; s < 6; s++) begin
      tick();
      r = cyc - t0;
      n_cmp++;
      if (obs() !== e_vec) begin
        n_bad++;
        $display("FAIL single_model r=%0d got=%b want=%b", r, obs(), e_vec);
      end
      n_cmp++;
      if ({gnt[0], a1, b2, done, busy} !==
          {r == 1, r <= 3, 1'b0, r == 3, r <= 4}) begin
        n_bad++;
        $display("FAIL single_timing r=%0d got g=%b a1=%b b2=%b d=%b bz=%b",
                 r, gnt[0], a1, b2, done, busy);
      end
      if (e_gnt[0]) req[0] = 1'b0;
    end
    drain();
  endtask

  task automatic test_rr();
    int g, last;
    logic [NREQ-1:0] want;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = '1;
    for (int i = 0; i < NREQ; i++) begin
      req_len[i*LENW +: LENW] = LENW'(1);
      req_tgt[i] = 1'($urandom_range(0, 1));
    end
    g = 0;
    last = 0;
    for (int s = 0; s < 16; s++) begin
      tick();
      n_cmp++;
      if (obs() !== e_vec) begin
        n_bad++;
        $display("FAIL rr_model cyc=%0d got=%b want=%b", cyc, obs(), e_vec);
      end
      n_cmp++;
      if (a1 && b2) begin
        n_bad++;
        $display("FAIL rr_overlap cyc=%0d got a1=%b b2=%b want not both",
                 cyc, a1, b2);
      end
      if (gnt != '0) begin
        want = '0;
        want[g % NREQ] = 1'b1;
        n_cmp++;
        if (gnt !== want || (g > 0 && cyc - last != 3)) begin
          n_bad++;
          $display("FAIL rr_order n=%0d got=%b gap=%0d want=%b gap=3",
                   g, gnt, cyc - last, want);
        end
        last = cyc;
        g++;
      end
    end
    n_cmp++;
    if (g < 5) begin
      n_bad++;
      $display("FAIL rr_count got=%0d want>=5", g);
    end
    req = '0;
    drain();
  endtask

  task automatic test_zero_len();
    int t0, r;
    req[2] = 1'b1;
    req_tgt[2] = 1'($urandom_range(0, 1));
    req_len[2*LENW +: LENW] = '0;
    t0 = cyc;
    for (int s = 0; s < 5; s++) begin
      tick();
      r = cyc - t0;
      n_cmp++;
      if (obs() !== e_vec) begin
        n_bad++;
        $display("FAIL zero_model r=%0d got=%b want=%b", r, obs(), e_vec);
      end
      n_cmp++;
      if ({gnt[2], done, a1 | b2, busy} !==
          {r == 1, r == 1, 1'b0, r <= 2}) begin
        n_bad++;
        $display("FAIL zero_timing r=%0d got g=%b d=%b drv=%b bz=%b",
                 r, gnt[2], done, a1 | b2, busy);
      end
      if (e_gnt[2]) req[2] = 1'b0;
    end
    drain();
  endtask

  task automatic test_max_len();
    int t0, nb, na, dat;
    req[1] = 1'b1;
    req_tgt[1] = 1'b1;
    req_len[1*LENW +: LENW] = '1;
    t0 = cyc;
    nb = 0;
    na = 0;
    dat = -1;
    for (int s = 0; s < 19; s++) begin
      tick();
      n_cmp++;
      if (obs() !== e_vec) begin
        n_bad++;
        $display("FAIL max_model cyc=%0d got=%b want=%b", cyc, obs(), e_vec);
      end
      if (b2) nb++;
      if (a1) na++;
      if (done && dat < 0) dat = cyc - t0;
      if (e_gnt[1]) req[1] = 1'b0;
    end
    n_cmp++;
    if (nb != 15 || na != 0 || dat != 15) begin
      n_bad++;
      $display("FAIL max_len got b2=%0d a1=%0d done@%0d want 15 0 15",
               nb, na, dat);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    req = 4'b0100;
    req_tgt[2] = 1'b1;
    req_len[2*LENW +: LENW] = LENW'(5);
    tick();
    req = '0;
    tick();
    n_cmp++;
    if (obs() !== e_vec || b2 !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_drive got=%b want=%b", obs(), e_vec);
    end
    reset = 1'b1;
    req = 4'b1001;
    req_len[0 +: LENW] = LENW'(1);
    req_len[3*LENW +: LENW] = LENW'(1);
    tick();
    n_cmp++;
    if ({gnt, b2, a1, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL rmid_abort got=%b want=0", {gnt, b2, a1, busy, done});
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || obs() !== e_vec) begin
      n_bad++;
      $display("FAIL rmid_next got gnt=%b want=0001", gnt);
    end
    req = '0;
    drain();
  endtask

  task automatic test_len_change();
    int t0, r, na, nb, g1;
    req[0] = 1'b1;
    req_tgt[0] = 1'b0;
    req_len[0 +: LENW] = LENW'(4);
    t0 = cyc;
    na = 0;
    nb = 0;
    g1 = -1;
    for (int s = 0; s < 12; s++) begin
      tick();
      r = cyc - t0;
      n_cmp++;
      if (obs() !== e_vec) begin
        n_bad++;
        $display("FAIL chg_model r=%0d got=%b want=%b", r, obs(), e_vec);
      end
      if (r <= 5 && a1) na++;
      if (r <= 5 && b2) nb++;
      if (gnt[1] && g1 < 0) g1 = r;
      if (r == 1) begin
        req[0] = 1'b0;
        req_len[0 +: LENW] = LENW'(9);
        req_tgt[0] = 1'b1;
      end
      if (r == 5) begin
        req[1] = 1'b1;
        req_tgt[1] = 1'b0;
        req_len[1*LENW +: LENW] = LENW'(2);
      end
      if (e_gnt[1]) req[1] = 1'b0;
    end
    n_cmp++;
    if (na != 4 || nb != 0 || g1 != 7) begin
      n_bad++;
      $display("FAIL chg_len got a1=%0d b2=%0d gnt1@%0d want 4 0 7",
               na, nb, g1);
    end
    drain();
  endtask

  task automatic test_random();
    for (int s = 0; s < 800; s++) begin
      tick();
      n_cmp++;
      if (obs() !== e_vec) begin
        n_bad++;
        $display("FAIL rand_model cyc=%0d got=%b want=%b", cyc, obs(), e_vec);
      end
      n_cmp++;
      if (a1 && b2) begin
        n_bad++;
        $display("FAIL rand_overlap cyc=%0d got both high want exclusive",
                 cyc);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (e_gnt[i]) req[i] = 1'b0;
        else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 40) == 0) req[i] = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          req_tgt[i] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 9) == 0)
            req_len[i*LENW +: LENW] = '1;
          else
            req_len[i*LENW +: LENW] = LENW'($urandom_range(0, 6));
        end
      end
      reset = ($urandom_range(0, 150) == 0);
    end
    reset = 1'b0;
    req = '0;
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_zero_len();
    test_max_len();
    test_reset_mid();
    test_len_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
